a2d_arbiter: RTL and testbench

- Shares the single A2D converter interface (strt_cnv/chnnl/cnv_cmplt/A2D_res) between NUM_REQ requesters, for example motion controller sensor sweeps and the battery/aux monitor.
- Round-robin arbitration with one conversion in flight at a time.
- Sits between the requesters and the A2D SPI interface block.
- Returns the 12-bit result and a one-cycle done pulse to the granted requester.

---
 rtl/a2d_arb_pkg.sv | 22 ++
 rtl/a2d_arbiter_rr_pick.sv | 36 +++
 rtl/a2d_arbiter.sv | 170 +++++++++++++++++
 tb/tb_a2d_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_arb_pkg.sv
// a2d_arb_pkg
// Shared types and widths for the A2D arbiter slice.
//   state_t  : arbiter FSM states (IDLE, GRANT, WAIT, DONE)
//   CHNNL_W  : A2D channel select width
//   RES_W    : A2D conversion result width
//   IDX_W    : requester index width (covers up to 4 requesters)
//   WD_W     : watchdog counter width (used when A2D_TIMEOUT_EN is defined)
package a2d_arb_pkg;

   localparam int CHNNL_W = 3;
   localparam int RES_W   = 12;
   localparam int IDX_W   = 2;
   localparam int WD_W    = 14;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/a2d_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin selector. The search starts at last_gnt+1 and
// wraps around, so the most recently served requester has lowest priority.
// Ports:
//   req       : per-requester request vector
//   last_gnt  : index of the requester served most recently
//   winner    : index of the selected requester (0 when nothing requested)
//   any_valid : high when at least one request is pending
module rr_pick
   import a2d_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_gnt,
   output logic [IDX_W-1:0]   winner,
   output logic               any_valid
);

   // Walk offsets 1..NUM_REQ from last_gnt; the first pending request wins.
   // The inner loop keeps every bit-select constant so no variable index is
   // needed into req.
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && req[i] && (((int'(last_gnt) + k) % NUM_REQ) == i)) begin
               winner    = IDX_W'(i);
               any_valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/a2d_arbiter.sv
// a2d_arbiter
// Shares one A2D converter interface between NUM_REQ requesters using
// round-robin arbitration, one conversion in flight at a time.
// Optional watchdog: define A2D_TIMEOUT_EN to abort a conversion that never
// completes within TIMEOUT_CYC clocks of WAIT (err + done pulse, res kept).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   req        : per-requester request, held until that requester's done
//   req_chnnl  : 3-bit channel per requester, requester i at [3i+2:3i]
//   gnt        : one-hot grant, GRANT through DONE
//   done       : one-cycle pulse to the granted requester
//   res        : last captured conversion result
//   err        : one-cycle watchdog abort pulse (0 without A2D_TIMEOUT_EN)
//   strt_cnv   : one-cycle conversion start to the A2D interface
//   chnnl      : channel to the A2D interface
//   cnv_cmplt  : conversion complete level from the A2D interface
//   A2D_res    : conversion result, valid while cnv_cmplt is high
module a2d_arbiter
   import a2d_arb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = 8192
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [CHNNL_W*NUM_REQ-1:0] req_chnnl,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         done,
   output logic [RES_W-1:0]           res,
   output logic                       err,
   output logic                       strt_cnv,
   output logic [CHNNL_W-1:0]         chnnl,
   input  logic                       cnv_cmplt,
   input  logic [RES_W-1:0]           A2D_res
);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0]     last_gnt_q, last_gnt_d;
   logic [CHNNL_W-1:0]   chnnl_q, chnnl_d;
   logic [RES_W-1:0]     res_q, res_d;

   logic [IDX_W-1:0]     winner;
   logic                 any_valid;
   logic [CHNNL_W-1:0]   winner_chnnl;
   logic [NUM_REQ-1:0]   sel_oh;

`ifdef A2D_TIMEOUT_EN
   localparam logic [WD_W-1:0] TO_LAST = WD_W'(TIMEOUT_CYC - 1);

   logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
   logic                 timed_out_q, timed_out_d;
`else
   logic                 unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

   rr_pick #(
      .NUM_REQ   (NUM_REQ)
   ) u_rr_pick (
      .req       (req),
      .last_gnt  (last_gnt_q),
      .winner    (winner),
      .any_valid (any_valid)
   );

   // Channel of the round-robin winner and one-hot decode of the held grant.
   always_comb begin
      winner_chnnl = '0;
      sel_oh       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDX_W'(i)) begin
            winner_chnnl = req_chnnl[i*CHNNL_W +: CHNNL_W];
         end
         sel_oh[i] = (gnt_idx_q == IDX_W'(i));
      end
   end

   // Next-state logic. cnv_cmplt is only looked at in WAIT, so a stale or
   // stray completion level in any other state has no effect.
   always_comb begin
      state_d    = state_q;
      gnt_idx_d  = gnt_idx_q;
      last_gnt_d = last_gnt_q;
      chnnl_d    = chnnl_q;
      res_d      = res_q;
`ifdef A2D_TIMEOUT_EN
      wd_cnt_d    = wd_cnt_q;
      timed_out_d = timed_out_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               gnt_idx_d = winner;
               chnnl_d   = winner_chnnl;
               state_d   = GRANT;
`ifdef A2D_TIMEOUT_EN
               timed_out_d = 1'b0;
`endif
            end
         end
         GRANT: begin
            state_d = WAIT;
`ifdef A2D_TIMEOUT_EN
            wd_cnt_d = '0;
`endif
         end
         WAIT: begin
            // A completion in the same cycle as the watchdog limit wins.
            if (cnv_cmplt) begin
               res_d   = A2D_res;
               state_d = DONE;
            end
`ifdef A2D_TIMEOUT_EN
            else if (wd_cnt_q == TO_LAST) begin
               timed_out_d = 1'b1;
               state_d     = DONE;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
`endif
         end
         DONE: begin
            last_gnt_d = gnt_idx_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // last_gnt resets to the highest index so requester 0 wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_idx_q  <= '0;
         last_gnt_q <= IDX_W'(NUM_REQ - 1);
         chnnl_q    <= '0;
         res_q      <= '0;
`ifdef A2D_TIMEOUT_EN
         wd_cnt_q    <= '0;
         timed_out_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         gnt_idx_q  <= gnt_idx_d;
         last_gnt_q <= last_gnt_d;
         chnnl_q    <= chnnl_d;
         res_q      <= res_d;
`ifdef A2D_TIMEOUT_EN
         wd_cnt_q    <= wd_cnt_d;
         timed_out_q <= timed_out_d;
`endif
      end
   end

   // All outputs decode directly from registered state, so they are glitch
   // free and drop to reset values as soon as rst asserts.
   assign strt_cnv = (state_q == GRANT);
   assign gnt      = (state_q == IDLE) ? '0 : sel_oh;
   assign done     = (state_q == DONE) ? sel_oh : '0;
   assign chnnl    = chnnl_q;
   assign res      = res_q;
`ifdef A2D_TIMEOUT_EN
   assign err      = (state_q == DONE) && timed_out_q;
`else
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_a2d_arbiter.sv
// tb_a2d_arbiter
// Self-checking bench for a2d_arbiter (NUM_REQ=2, TIMEOUT_CYC=16).
// Stimulus pushes expected grants and completions into queues; a monitor
// pops and compares whenever the DUT raises strt_cnv or done/err.
// The watchdog scenario runs only when A2D_TIMEOUT_EN is defined.
module tb_a2d_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [5:0]  req_chnnl;
   logic [1:0]  gnt;
   logic [1:0]  done;
   logic [11:0] res;
   logic        err;
   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt;
   logic [11:0] A2D_res;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] gnt;
      logic [2:0] ch;
   } gnt_exp_t;

   typedef struct packed {
      logic [1:0]  done;
      logic [11:0] res;
      logic        err;
   } done_exp_t;

   gnt_exp_t  gnt_q[$];
   done_exp_t done_q[$];
   gnt_exp_t  mon_g;
   done_exp_t mon_d;

   a2d_arbiter #(
      .NUM_REQ     (2),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_chnnl (req_chnnl),
      .gnt       (gnt),
      .done      (done),
      .res       (res),
      .err       (err),
      .strt_cnv  (strt_cnv),
      .chnnl     (chnnl),
      .cnv_cmplt (cnv_cmplt),
      .A2D_res   (A2D_res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic report_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Scoreboard monitor: compares every grant and every completion.
   always @(negedge clk) begin
      if (!rst) begin
         if (gnt == 2'b11) report_fail("gnt_onehot", 32'(gnt), 32'h0);
         if (strt_cnv) begin
            if (gnt_q.size() == 0) begin
               report_fail("unexpected_strt_cnv", 32'(strt_cnv), 32'h0);
            end else begin
               mon_g = gnt_q.pop_front();
               check_output("grant_chnnl", 32'(chnnl), 32'(mon_g.ch));
               check_output("grant_gnt", 32'(gnt), 32'(mon_g.gnt));
            end
         end
         if ((done != 2'b00) || err) begin
            if (done_q.size() == 0) begin
               report_fail("unexpected_done", 32'({err, done}), 32'h0);
            end else begin
               mon_d = done_q.pop_front();
               check_output("done_vec", 32'(done), 32'(mon_d.done));
               check_output("done_res", 32'(res), 32'(mon_d.res));
               check_output("done_err", 32'(err), 32'(mon_d.err));
            end
         end
      end
   end

   task automatic apply_stimulus(input logic [1:0] r, input logic [2:0] c0, input logic [2:0] c1);
      req       = r;
      req_chnnl = {c1, c0};
   endtask

   // Counts falling edges until strt_cnv is seen (first edge counts as 1).
   task automatic wait_strt(output int n);
      for (n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (strt_cnv) break;
      end
      if (n > 100) report_fail("strt_cnv_wait", 32'h0, 32'h1);
   endtask

   task automatic wait_done(output int n);
      for (n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (done != 2'b00) break;
      end
      if (n > 100) report_fail("done_wait", 32'h0, 32'h1);
   endtask

   // Drives cnv_cmplt for one sampling edge, dly rising edges from now.
   task automatic pulse_cmplt(input int dly, input logic [11:0] v);
      repeat (dly) @(posedge clk);
      #1;
      cnv_cmplt = 1'b1;
      A2D_res   = v;
      @(posedge clk);
      #1;
      cnv_cmplt = 1'b0;
      A2D_res   = 12'hFFF;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      int n;
      rst       = 1'b0;
      req       = 2'b00;
      req_chnnl = 6'd0;
      cnv_cmplt = 1'b0;
      A2D_res   = 12'hFFF;
      #2 rst = 1'b1;
      #2;
      check_output("reset_gnt", 32'(gnt), 32'h0);
      check_output("reset_done", 32'(done), 32'h0);
      check_output("reset_res", 32'(res), 32'h0);
      check_output("reset_err", 32'(err), 32'h0);
      check_output("reset_strt", 32'(strt_cnv), 32'h0);
      check_output("reset_chnnl", 32'(chnnl), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] single request");
      @(posedge clk);
      #1;
      gnt_q.push_back('{gnt: 2'b01, ch: 3'd4});
      apply_stimulus(2'b01, 3'd4, 3'd0);
      wait_strt(n);
      check_output("strt_latency", 32'(n), 32'd2);
      done_q.push_back('{done: 2'b01, res: 12'hA5C, err: 1'b0});
      pulse_cmplt(10, 12'hA5C);
      wait_done(n);
      check_output("done_latency", 32'(n), 32'd1);
      @(posedge clk);
      #1 req = 2'b00;

      $display("[TB] contention after reset");
      pulse_reset();
      gnt_q.push_back('{gnt: 2'b01, ch: 3'd1});
      gnt_q.push_back('{gnt: 2'b10, ch: 3'd7});
      apply_stimulus(2'b11, 3'd1, 3'd7);
      done_q.push_back('{done: 2'b01, res: 12'h111, err: 1'b0});
      wait_strt(n);
      pulse_cmplt(2, 12'h111);
      wait_done(n);
      @(posedge clk);
      #1 req = 2'b10;
      done_q.push_back('{done: 2'b10, res: 12'h777, err: 1'b0});
      wait_strt(n);
      pulse_cmplt(2, 12'h777);
      wait_done(n);
      @(posedge clk);
      #1 req = 2'b00;

      $display("[TB] fairness");
      for (int i = 0; i < 6; i++) begin
         gnt_q.push_back('{gnt: (i % 2 == 0) ? 2'b01 : 2'b10, ch: (i % 2 == 0) ? 3'd2 : 3'd6});
         done_q.push_back('{done: (i % 2 == 0) ? 2'b01 : 2'b10, res: 12'h100 + 12'(i), err: 1'b0});
      end
      apply_stimulus(2'b11, 3'd2, 3'd6);
      for (int i = 0; i < 6; i++) begin
         wait_strt(n);
         if (i > 0) check_output("rr_gap", 32'(n), 32'd2);
         pulse_cmplt(1, 12'h100 + 12'(i));
         wait_done(n);
      end
      @(posedge clk);
      #1 req = 2'b00;

      $display("[TB] late drop");
      gnt_q.push_back('{gnt: 2'b01, ch: 3'd2});
      done_q.push_back('{done: 2'b01, res: 12'hABC, err: 1'b0});
      apply_stimulus(2'b01, 3'd2, 3'd0);
      wait_strt(n);
      @(posedge clk);
      #1 req = 2'b00;
      pulse_cmplt(3, 12'hABC);
      wait_done(n);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_output("idle_strt", 32'(strt_cnv), 32'h0);
         check_output("idle_gnt", 32'(gnt), 32'h0);
      end

      $display("[TB] reset mid-conversion");
      gnt_q.push_back('{gnt: 2'b10, ch: 3'd5});
      apply_stimulus(2'b10, 3'd0, 3'd5);
      wait_strt(n);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      req = 2'b00;
      #1;
      check_output("midrst_gnt", 32'(gnt), 32'h0);
      check_output("midrst_res", 32'(res), 32'h0);
      check_output("midrst_strt", 32'(strt_cnv), 32'h0);
      check_output("midrst_chnnl", 32'(chnnl), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      cnv_cmplt = 1'b1;
      A2D_res   = 12'h555;
      @(posedge clk);
      #1 cnv_cmplt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_output("stray_done", 32'(done), 32'h0);
         check_output("stray_res", 32'(res), 32'h0);
      end

`ifdef A2D_TIMEOUT_EN
      $display("[TB] watchdog timeout");
      gnt_q.push_back('{gnt: 2'b01, ch: 3'd3});
      gnt_q.push_back('{gnt: 2'b01, ch: 3'd3});
      done_q.push_back('{done: 2'b01, res: 12'h3C1, err: 1'b0});
      done_q.push_back('{done: 2'b01, res: 12'h3C1, err: 1'b1});
      apply_stimulus(2'b01, 3'd3, 3'd0);
      wait_strt(n);
      pulse_cmplt(2, 12'h3C1);
      wait_done(n);
      wait_strt(n);
      wait_done(n);
      check_output("timeout_latency", 32'(n), 32'd17);
      @(posedge clk);
      #1 req = 2'b00;
`endif

      repeat (5) @(negedge clk);
      check_output("gnt_queue_empty", 32'(gnt_q.size()), 32'h0);
      check_output("done_queue_empty", 32'(done_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
